pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
//==========================================================================
// Module   : pc_fetch_unit
// Purpose  : Single-outstanding instruction fetch FSM with next-PC select
//            and flush/redirect. Macro PC_MISALIGN_TRAP_EN sends misaligned
//            targets to TRAP_VECTOR and pulses misalign.
// Revision : 1.0 - initial release
//==========================================================================
module pc_fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] c_four       = XLEN'(4);
    localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_drop;
    logic [XLEN-1:0] w_raw_target;
    logic [XLEN-1:0] w_target;
    logic            w_load_addr;
    logic            w_capture;
    logic            w_drop_set;
    logic            w_drop_clr;
    logic            w_imem_req;
    logic            w_instr_valid;

    // pc+4 is relative to the current fetch address, which equals pc in HOLD
    always_comb begin
        case (pc_sel)
            2'b00:   w_raw_target = r_addr + c_four;
            2'b01:   w_raw_target = branch_target;
            2'b10:   w_raw_target = jalr_target;
            default: w_raw_target = TRAP_VECTOR;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;

    assign w_misaligned = |w_raw_target[1:0];
    assign w_target     = w_misaligned ? TRAP_VECTOR : w_raw_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_load_addr & w_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    assign w_target = w_raw_target & c_align_mask;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_load_addr   = 1'b0;
        w_capture     = 1'b0;
        w_drop_set    = 1'b0;
        w_drop_clr    = 1'b0;
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                w_imem_req = 1'b1;
                if (flush) begin
                    w_load_addr = 1'b1;
                    // A granted-but-unreturned request must have its data dropped
                    if (imem_gnt && !imem_rvalid) begin
                        w_drop_set   = 1'b1;
                        w_next_state = S_WAIT;
                    end
                end else if (imem_gnt) begin
                    if (imem_rvalid) begin
                        w_capture    = 1'b1;
                        w_next_state = S_HOLD;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_load_addr = 1'b1;
                end
                if (imem_rvalid) begin
                    w_drop_clr = 1'b1;
                    if (flush || r_drop) begin
                        w_next_state = S_REQ;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = S_HOLD;
                    end
                end else if (flush) begin
                    w_drop_set = 1'b1;
                end
            end
            S_HOLD: begin
                w_instr_valid = 1'b1;
                if (instr_ready || flush) begin
                    w_load_addr  = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= RESET_VECTOR;
            r_pc    <= RESET_VECTOR;
            r_instr <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_load_addr) begin
                r_addr <= w_target;
            end
            if (w_capture) begin
                r_instr <= imem_rdata;
                r_pc    <= r_addr;
            end
            if (w_drop_set) begin
                r_drop <= 1'b1;
            end else if (w_drop_clr) begin
                r_drop <= 1'b0;
            end
        end
    end

    assign imem_req    = w_imem_req;
    assign imem_addr   = r_addr;
    assign instr_valid = w_instr_valid;
    assign instr       = r_instr;
    assign pc          = r_pc;

endmodule
`default_nettype wire
